// File: rtl/range_sched_pkg.sv
// Shared types and default widths for the range-rule search scheduler.
package range_sched_pkg;

    localparam int NUM_RULES_DEF = 8;
    localparam int IDX_W_DEF     = 3;
    localparam int KEY_W_DEF     = 16;
    localparam int PIPE_LAT_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [KEY_W_DEF-1:0] lower;
        logic [KEY_W_DEF-1:0] upper;
        logic                 en;
    } rule_t;

    typedef struct packed {
        logic                 valid;
        logic [IDX_W_DEF-1:0] idx;
        logic                 en;
    } tag_t;

endpackage

// File: rtl/range_tag_pipe.sv
// Tag shift register that tracks which rule each in-flight matcher result belongs to.
module range_tag_pipe
    import range_sched_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t tag_p [PIPE_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE_LAT; s++) tag_p[s] <= '0;
        end else begin
            tag_p[0] <= tag_in;
            for (int s = 1; s < PIPE_LAT; s++) tag_p[s] <= tag_p[s-1];
        end
    end

    assign tag_out = tag_p[PIPE_LAT-1];

endmodule

// File: rtl/range_match_scheduler.sv
// Time-shares one external range matcher across a rule table and reports the
// lowest-index enabled rule whose [lower, upper] range contains the search key.
module range_match_scheduler
    import range_sched_pkg::*;
#(
    parameter int NUM_RULES = NUM_RULES_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int KEY_W     = KEY_W_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [KEY_W-1:0] cfg_lower,
    input  logic [KEY_W-1:0] cfg_upper,
    input  logic             cfg_en,
    output logic             cfg_ready,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key,
    output logic             key_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    output logic [KEY_W-1:0] m_in,
    output logic [KEY_W-1:0] m_lower,
    output logic [KEY_W-1:0] m_upper,
    input  logic             m_match
);

    state_t           state, state_nxt;
    rule_t            rules [NUM_RULES];
    rule_t            cur_rule;
    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] issue_idx;
    logic             hit_q;
    logic [IDX_W-1:0] hit_idx_q;
    tag_t             tag_in, tag_tail;
    logic             key_fire, cfg_fire, last_eval, eval_hit;

    assign key_fire  = key_valid && key_ready;
    assign cfg_fire  = cfg_we && cfg_ready;
    assign cur_rule  = rules[issue_idx];
    assign last_eval = tag_tail.valid && (tag_tail.idx == IDX_W'(NUM_RULES - 1));
    assign eval_hit  = tag_tail.valid && tag_tail.en && m_match && !hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_fire) state_nxt = ISSUE;
            ISSUE:   if (issue_idx == IDX_W'(NUM_RULES - 1)) state_nxt = DRAIN;
            DRAIN:   if (last_eval) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_ready = 1'b0;
        cfg_ready = 1'b0;
        res_valid = 1'b0;
        m_in      = '0;
        m_lower   = '0;
        m_upper   = '0;
        tag_in    = '0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                cfg_ready = 1'b1;
            end
            ISSUE: begin
                m_in    = key_q;
                m_lower = cur_rule.lower;
                m_upper = cur_rule.upper;
                // Disabled rules still occupy a slot so result latency never varies.
                tag_in  = '{valid: 1'b1, idx: issue_idx, en: cur_rule.en};
            end
            DONE:    res_valid = 1'b1;
            default: ;
        endcase
    end

    // Out-of-range indices match no entry and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_RULES; r++) rules[r] <= '0;
        end else if (cfg_fire) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                if (cfg_idx == IDX_W'(r))
                    rules[r] <= '{lower: cfg_lower, upper: cfg_upper, en: cfg_en};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q     <= '0;
            issue_idx <= '0;
        end else if (key_fire) begin
            key_q     <= key;
            issue_idx <= '0;
        end else if (state == ISSUE) begin
            issue_idx <= issue_idx + 1'b1;
        end
    end

    // First recorded hit wins; rules come back in ascending index order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else if (key_fire) begin
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else if (eval_hit) begin
            hit_q     <= 1'b1;
            hit_idx_q <= tag_tail.idx;
        end
    end

    assign res_hit = hit_q;
    assign res_idx = hit_idx_q;

    range_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .tag_in  (tag_in),
        .tag_out (tag_tail)
    );

endmodule

// File: tb/tb_range_match_scheduler.sv
// Scoreboard bench for range_match_scheduler with a behavioural pipelined range matcher.
module tb_range_match_scheduler;

    localparam int NR = 8;
    localparam int IW = 3;
    localparam int KW = 16;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [KW-1:0] cfg_lower = '0;
    logic [KW-1:0] cfg_upper = '0;
    logic          cfg_en = 1'b0;
    logic          cfg_ready;
    logic          key_valid = 1'b0;
    logic [KW-1:0] key = '0;
    logic          key_ready;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_hit;
    logic [IW-1:0] res_idx;
    logic [KW-1:0] m_in, m_lower, m_upper;
    logic          m_match;
    logic [PL-1:0] mpipe = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic          hit;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t          sb_q[$];
    logic [KW-1:0] mdl_lo [NR];
    logic [KW-1:0] mdl_hi [NR];
    logic          mdl_en [NR];

    range_match_scheduler #(
        .NUM_RULES (NR),
        .IDX_W     (IW),
        .KEY_W     (KW),
        .PIPE_LAT  (PL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_lower (cfg_lower),
        .cfg_upper (cfg_upper),
        .cfg_en    (cfg_en),
        .cfg_ready (cfg_ready),
        .key_valid (key_valid),
        .key       (key),
        .key_ready (key_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_hit   (res_hit),
        .res_idx   (res_idx),
        .m_in      (m_in),
        .m_lower   (m_lower),
        .m_upper   (m_upper),
        .m_match   (m_match)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Matcher: result for operands presented in cycle c appears in cycle c+PL.
    always @(posedge clk) mpipe <= {mpipe[PL-2:0], (m_in >= m_lower) && (m_in <= m_upper)};
    assign m_match = mpipe[PL-1];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [KW-1:0] k);
        exp_t e;
        e.hit = 1'b0;
        e.idx = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (mdl_en[i] && k >= mdl_lo[i] && k <= mdl_hi[i]) begin
                e.hit = 1'b1;
                e.idx = IW'(i);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && res_valid && res_ready) begin
            check_val("sb_pending", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_val("res_hit", 32'(res_hit), 32'(e.hit));
                check_val("res_idx", 32'(res_idx), 32'(e.idx));
            end
        end
    end

    task automatic cfg_write(input int idx, input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                             input logic en);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_lower = lo; cfg_upper = hi; cfg_en = en;
        @(negedge clk);
        check_val("cfg_ready_idle", 32'(cfg_ready), 1);
        mdl_lo[idx] = lo; mdl_hi[idx] = hi; mdl_en[idx] = en;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic run_search(input logic [KW-1:0] k, input int hold, input bit inject);
        int t0;
        bit ok;
        @(posedge clk); #1;
        key_valid = 1'b1; key = k;
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (key_ready) ok = 1'b1;
        end
        check_val("key_accept", 32'(ok), 1);
        if (!ok) begin
            key_valid = 1'b0;
            return;
        end
        t0 = cyc;
        sb_q.push_back(model(k));
        @(posedge clk); #1;
        key_valid = 1'b0;
        if (inject) begin
            cfg_we = 1'b1; cfg_idx = 3'd2; cfg_lower = 16'h3000; cfg_upper = 16'h30FF; cfg_en = 1'b1;
            @(negedge clk);
            check_val("cfg_ready_busy", 32'(cfg_ready), 0);
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        ok = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge clk);
            if (res_valid) ok = 1'b1;
        end
        check_val("res_valid_seen", 32'(ok), 1);
        if (!ok) begin
            sb_q.delete(sb_q.size() - 1);
            return;
        end
        check_val("latency", 32'(cyc - t0), NR + PL + 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("hold_valid", 32'(res_valid), 1);
            check_val("hold_idx", 32'(res_idx), 32'(sb_q[0].idx));
            check_val("hold_key_ready", 32'(key_ready), 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check_val("post_res_valid", 32'(res_valid), 0);
        check_val("post_key_ready", 32'(key_ready), 1);
        check_val("post_m_in", 32'(m_in), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int vcnt;
        for (int i = 0; i < NR; i++) begin
            mdl_lo[i] = '0; mdl_hi[i] = '0; mdl_en[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_val("rst_res_valid", 32'(res_valid), 0);
        check_val("rst_res_hit", 32'(res_hit), 0);
        check_val("rst_res_idx", 32'(res_idx), 0);
        check_val("rst_m_lower", 32'(m_lower), 0);
        check_val("rst_m_upper", 32'(m_upper), 0);
        check_val("rst_key_ready", 32'(key_ready), 1);
        check_val("rst_cfg_ready", 32'(cfg_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;

        cfg_write(2, 16'h1000, 16'h1FFF, 1'b1);
        cfg_write(5, 16'h0000, 16'hFFFF, 1'b1);
        run_search(16'h1234, 0, 1'b0);
        run_search(16'h3000, 0, 1'b0);

        cfg_write(2, 16'h1000, 16'h1FFF, 1'b0);
        cfg_write(5, 16'h0000, 16'hFFFF, 1'b0);
        run_search(16'h1234, 0, 1'b0);

        cfg_write(0, 16'h00FF, 16'h0100, 1'b1);
        run_search(16'h00FF, 0, 1'b0);
        run_search(16'h0100, 0, 1'b0);
        run_search(16'h00FE, 0, 1'b0);
        run_search(16'h0101, 0, 1'b0);

        cfg_write(2, 16'h1000, 16'h1FFF, 1'b1);
        cfg_write(5, 16'h0000, 16'hFFFF, 1'b1);
        run_search(16'h1234, 5, 1'b1);
        run_search(16'h3000, 0, 1'b0);

        // Abort a search with reset partway through the issue phase.
        @(posedge clk); #1;
        key_valid = 1'b1; key = 16'h1234;
        @(negedge clk);
        check_val("abort_key_ready", 32'(key_ready), 1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_rst_valid", 32'(res_valid), 0);
        check_val("abort_rst_key_ready", 32'(key_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            mdl_lo[i] = '0; mdl_hi[i] = '0; mdl_en[i] = 1'b0;
        end
        vcnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (res_valid) vcnt++;
        end
        check_val("abort_no_result", 32'(vcnt), 0);
        check_val("abort_key_ready_after", 32'(key_ready), 1);
        run_search(16'h1234, 0, 1'b0);
        run_search(16'h0000, 0, 1'b0);

        check_val("sb_drained", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/range_match_scheduler.md
Name: range_match_scheduler

Overview:
Controller that shares one range_bit_vector_encoding matcher across a table of NUM_RULES range rules. It holds a register table of lower and upper bounds and accepts one search key at a time over a valid/ready handshake. It streams key/rule pairs into the matcher one per cycle, collects the pipelined match bits and reports the lowest-index matching rule. It sits between the packet-classification front end and the matcher instance, which sits beside it at the top level.

Parameters:
NUM_RULES, 8, number of rule entries
IDX_W, 3, rule index width, equal to clog2(NUM_RULES)
KEY_W, 16, key and bound width (matches matcher)
PIPE_LAT, 4, cycles from driving m_in/m_lower/m_upper to the corresponding m_match

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_we  in  1  rule write strobe
cfg_idx  in  IDX_W  rule index to write
cfg_lower  in  KEY_W  rule lower bound (inclusive)
cfg_upper  in  KEY_W  rule upper bound (inclusive)
cfg_en  in  1  rule enable
cfg_ready  out  1  write accepted when cfg_we&cfg_ready
key_valid  in  1  search request
key  in  KEY_W  search key
key_ready  out  1  key accepted when key_valid&key_ready
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid&res_ready
res_hit  out  1  some enabled rule matched
res_idx  out  IDX_W  lowest matching rule index, 0 on miss
m_in  out  KEY_W  matcher key operand
m_lower  out  KEY_W  matcher lower bound
m_upper  out  KEY_W  matcher upper bound
m_match  in  1  matcher result

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all rule lower/upper/en=0; tag pipe cleared; res_valid=0, res_hit=0, res_idx=0; m_*=0. key_ready and cfg_ready read 1, but handshakes are ignored while rst=0.
- FSM states IDLE, ISSUE, DRAIN, DONE.
- IDLE: key_ready=1, cfg_ready=1. A cfg write with cfg_idx<NUM_RULES updates the entry at the edge. cfg_idx>=NUM_RULES is ignored. On key handshake: latch key, issue_idx=0, clear hit tracker, go ISSUE. A write and a key handshake in the same cycle are both taken, and the search uses the updated table.
- ISSUE: drive m_in=key_q, m_lower/m_upper=rule[issue_idx]. Push tag {valid=1, idx=issue_idx, en=rule.en} into a PIPE_LAT-deep shift register. Disabled rules are still issued so timing stays fixed. issue_idx increments. After issuing NUM_RULES-1, go DRAIN.
- DRAIN: m_*=0 and invalid tags are pushed. Go DONE on the cycle the last valid tag is evaluated.
- Evaluation, in any state: when the tail tag is valid and tag.en and m_match are set and no hit has been recorded, record hit=1, idx=tag.idx. Lowest index wins because rules are issued in ascending order.
- DONE: res_valid=1, res_hit/res_idx stable. On res_ready go IDLE; res_valid drops next cycle. key_ready=0 and cfg_ready=0 in ISSUE, DRAIN and DONE. cfg_we is ignored there and the table is untouched.
- Outside ISSUE, m_* are held at 0.
- Latency: key accepted at edge of cycle T. Rule i is issued in cycle T+1+i, and its m_match is sampled in cycle T+1+i+PIPE_LAT. res_valid first high in cycle T+NUM_RULES+PIPE_LAT+1, which is 13 at the defaults. Throughput is one search per NUM_RULES+PIPE_LAT+2 cycles minimum.
- res_ready held low: result held indefinitely, no new key accepted.
- Reset mid-search: search aborted, no res_valid, table cleared.

Decomposition:
- Package range_sched_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), rule struct {lower, upper, en}, tag struct {valid, idx, en}, default width constants.
- One sub-module, range_tag_pipe: a PIPE_LAT-stage tag shift register with async active-low clear.
- The matcher is instantiated beside this block at the top level, not inside it.

Test Plan:
- Rule2=[0x1000,0x1FFF] en, rule5=[0x0000,0xFFFF] en, others disabled. Key 0x1234 accepted at cycle 0 -> res_valid in cycle 13, res_hit=1, res_idx=2.
- Same table, key 0x3000 -> res_hit=1, res_idx=5.
- All rules disabled, including a rule whose range covers the key; key 0x1234 -> res_hit=0, res_idx=0, same 13-cycle latency.
- Rule0=[0x00FF,0x0100] en only. Keys 0x00FF and 0x0100 -> hit idx0; keys 0x00FE and 0x0101 -> miss.
- cfg_we to rule2 during ISSUE -> cfg_ready=0 and the write is lost; the next search shows the old bounds. res_ready low for 5 cycles in DONE -> res_valid/res_idx stable and key_ready=0 throughout.
- rst pulled low in cycle 3 of ISSUE -> res_valid never asserts. After release: key_ready=1, all rules disabled, and a new key returns a miss.
